// File: rtl/nios_led3_ledr_fader.sv
// LEDR fader: each channel ramps an 8-bit PWM duty up or down when its
// registered control bit changes, instead of switching the LED hard.
module nios_led3_ledr_fader #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned NUM_LEDS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_ctrl,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] ST_OFF      = 2'd0;
  localparam logic [1:0] ST_FADE_IN  = 2'd1;
  localparam logic [1:0] ST_ON       = 2'd2;
  localparam logic [1:0] ST_FADE_OUT = 2'd3;

  logic [NUM_LEDS-1:0] r_ctrl;
  logic [PW-1:0]       r_presc;
  logic [7:0]          r_pwm;
  logic [1:0]          r_state [NUM_LEDS];
  logic [7:0]          r_duty  [NUM_LEDS];
  logic [NUM_LEDS-1:0] r_led;
  logic                r_busy;

  logic                w_tick;
  logic [1:0]          w_state_d [NUM_LEDS];
  logic [7:0]          w_duty_d  [NUM_LEDS];
  logic [NUM_LEDS-1:0] w_led_d;
  logic                w_busy_d;

  assign w_tick  = (r_presc == PW'(PRESCALE - 1));
  assign led_out = r_led;
  assign busy    = r_busy;

  // Prescaler phase depends only on time since reset, never on led_ctrl.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl  <= '0;
      r_presc <= '0;
      r_pwm   <= 8'd0;
    end else begin
      r_ctrl  <= led_ctrl;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_pwm   <= r_pwm + 8'd1;
    end
  end

  always_comb begin
    w_busy_d = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_state_d[i] = r_state[i];
      w_duty_d[i]  = r_duty[i];
      w_led_d[i]   = 1'b0;
      // A direction change always takes precedence over a tick.
      case (r_state[i])
        ST_OFF: begin
          if (r_ctrl[i]) w_state_d[i] = ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (!r_ctrl[i]) begin
            w_state_d[i] = ST_FADE_OUT;
          end else if (w_tick) begin
            if (r_duty[i] != 8'd255) w_duty_d[i] = r_duty[i] + 8'd1;
            if (r_duty[i] >= 8'd254) w_state_d[i] = ST_ON;
          end
        end
        ST_ON: begin
          if (!r_ctrl[i]) w_state_d[i] = ST_FADE_OUT;
        end
        default: begin
          if (r_ctrl[i]) begin
            w_state_d[i] = ST_FADE_IN;
          end else if (w_tick) begin
            if (r_duty[i] != 8'd0) w_duty_d[i] = r_duty[i] - 8'd1;
            if (r_duty[i] <= 8'd1) w_state_d[i] = ST_OFF;
          end
        end
      endcase

      case (r_state[i])
        ST_ON:   w_led_d[i] = 1'b1;
        ST_OFF:  w_led_d[i] = 1'b0;
        default: w_led_d[i] = (r_pwm < r_duty[i]);
      endcase

      if (r_state[i] == ST_FADE_IN || r_state[i] == ST_FADE_OUT) w_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_state[i] <= ST_OFF;
        r_duty[i]  <= 8'd0;
      end
      r_led  <= '0;
      r_busy <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_state[i] <= w_state_d[i];
        r_duty[i]  <= w_duty_d[i];
      end
      r_led  <= w_led_d;
      r_busy <= w_busy_d;
    end
  end

endmodule

// File: doc/nios_led3_ledr_fader.md
# nios_led3_ledr_fader

Downstream stage of the LEDR parallel output port. Consumes the 2-bit LEDR control word and drives the two physical red LEDs. Each LED ramps its brightness through an 8-bit PWM duty rather than switching hard: a 0→1 control transition starts a fade-in, and a 1→0 transition starts a fade-out. Sits between the LEDR PIO `out_port` and the top-level LEDR pins, on the system clock.

## Interface
Parameters:
- `PRESCALE`, default 50000: system clocks per fade tick (1 kHz tick at 50 MHz); legal range ≥ 2.
- `NUM_LEDS`, default 2: number of channels; must match the PIO width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `led_ctrl`  in  NUM_LEDS  LED request, driven from PIO `out_port`; bit i = 1 requests LED i on.
- `led_out`  out  NUM_LEDS  PWM drive to the LEDR pins; active-high.
- `busy`  out  1  high while any channel is in FADE_IN or FADE_OUT.

## Operation
- **Input register.** `led_ctrl` is registered into `ctrl_q` every cycle. All decisions use `ctrl_q`.
- **Prescaler.** Counts 0..PRESCALE-1 and wraps. `tick` is a one-cycle pulse when count == PRESCALE-1.
- **PWM counter.** 8 bits, free-running, increments every clock and wraps 255→0.
- **Per-channel state.** Each channel has an 8-bit `duty` and an FSM with states OFF, FADE_IN, ON, FADE_OUT.
  - OFF: if ctrl_q=1, go to FADE_IN; duty stays 0.
  - FADE_IN:
    - If ctrl_q=0, go to FADE_OUT with duty held (reversal from the current level).
    - Else on tick, duty+1. When the incremented duty equals 255, go to ON in the same update.
  - ON: if ctrl_q=0, go to FADE_OUT; duty stays 255.
  - FADE_OUT:
    - If ctrl_q=1, go to FADE_IN with duty held.
    - Else on tick, duty−1. When the decremented duty equals 0, go to OFF in the same update.
- **Precedence.** When a direction change and a tick occur in the same cycle, the direction change wins and duty is unchanged that cycle.
- **Duty bounds.** Duty never wraps: no increment at 255, no decrement at 0.
- **Output compare** (registered):
  - ON: led_out[i] = 1.
  - OFF: led_out[i] = 0.
  - Fading: led_out[i] = (pwm_cnt < duty[i]).
- **busy.** Registered OR of (state ∈ {FADE_IN, FADE_OUT}) over all channels.
- **Channel independence.** Channels run independently and share only the prescaler and the PWM counter.
- **Reset.** Asserting reset_n low mid-fade forces OFF immediately (asynchronous). No fade-out occurs.

## Timing
- **Reset values:**
  - led_out = 0, busy = 0.
  - All duty = 0, all states OFF.
  - Prescaler = 0, pwm_cnt = 0, ctrl_q = 0.
- **Latency from a led_ctrl edge:**
  - Cycle 1: ctrl_q updates.
  - Cycle 2: state changes.
  - Cycle 3: busy and the led_out compare reflect the new state.
- **Full fade duration.** A complete fade 0→255 or 255→0 takes 255 ticks = 255·PRESCALE clocks, ±PRESCALE depending on prescaler phase.
- **PWM period.** 256 clocks. At duty d the output is high for d clocks per period while fading.
- **Prescaler phase.** The prescaler is never reset by led_ctrl activity; tick phase depends only on time since reset.
- **Pulse handling.** A led_ctrl pulse of one cycle is honoured: FADE_IN is entered, then reversed to FADE_OUT the cycle after.

## Test plan
All tests use PRESCALE=4.
- **Reset.** Hold reset_n=0 for 5 cycles with led_ctrl=2'b11 → led_out=0, busy=0. Release → busy rises at cycle 3 after release, both channels enter FADE_IN.
- **Full fade-in.** led_ctrl=2'b01 from OFF → duty[0] reaches 255 after 255 ticks (~1020 clocks). ch0 enters ON, led_out[0] steady 1, busy falls. led_out[1] stays 0 throughout.
- **Full fade-out.** From ON, led_ctrl=0 → duty[0] decrements once per tick and reaches 0 at ~1020 clocks. led_out[0] = 0 thereafter, busy = 0.
- **Reversal.** Set led_ctrl[0]=1, then clear it after 100 ticks (duty=100) → FADE_OUT starts with duty held at 100. OFF is reached 100 ticks later. No duty jump is observed.
- **Tick/edge coincidence.** Align a led_ctrl change so the state change falls on a tick cycle → duty unchanged that cycle. A PWM duty check at duty=64 shows led_out high for exactly 64 of 256 clocks.
- **Async reset mid-fade.** Assert reset_n low while both channels are in FADE_IN → led_out and busy go 0 without waiting for a clock edge. After release, the channels restart from duty 0.
